// File: rtl/booth_r4_encoder_seq_pkg.sv
// Shared Booth radix-4 constants, state encoding and group helpers.
// Both the recoder and the downstream partial-product selector import this package.
package booth_r4_encoder_seq_pkg;

  // 3-bit group codes {b[2i+1], b[2i], b[2i-1]}
  localparam logic [2:0] BOOTH_ZERO_P = 3'b000;
  localparam logic [2:0] BOOTH_P1A_A  = 3'b001;
  localparam logic [2:0] BOOTH_P1A_B  = 3'b010;
  localparam logic [2:0] BOOTH_P2A    = 3'b011;
  localparam logic [2:0] BOOTH_M2A    = 3'b100;
  localparam logic [2:0] BOOTH_M1A_A  = 3'b101;
  localparam logic [2:0] BOOTH_M1A_B  = 3'b110;
  localparam logic [2:0] BOOTH_ZERO_N = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic booth_is_zero(input logic [2:0] g);
    return (g == BOOTH_ZERO_P) || (g == BOOTH_ZERO_N);
  endfunction

  // Signed multiple of A selected by a group: -2..+2
  function automatic logic signed [2:0] booth_digit(input logic [2:0] g);
    logic signed [2:0] d;
    d = 3'sd0;
    case (g)
      BOOTH_P1A_A, BOOTH_P1A_B: d = 3'sd1;
      BOOTH_P2A:                d = 3'sd2;
      BOOTH_M2A:                d = -3'sd2;
      BOOTH_M1A_A, BOOTH_M1A_B: d = -3'sd1;
      default:                  d = 3'sd0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_encoder_seq_if.sv
// Multiplier-in / Booth-group-out stream bundle for the radix-4 recoder.
interface booth_r4_encoder_seq_if #(
  parameter int N = 32
);
  localparam int IW = $clog2(N / 2);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    out_cntrl;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          busy;

  modport slave (
    input  in_valid, in_b, out_ready,
    output in_ready, out_valid, out_cntrl, out_idx, out_last, busy
  );

  modport master (
    output in_valid, in_b, out_ready,
    input  in_ready, out_valid, out_cntrl, out_idx, out_last, busy
  );

endinterface

// File: rtl/booth_r4_encoder_seq.sv
// Sequential radix-4 Booth recoder: one 3-bit group per cycle, LSB-first,
// streamed with its index and a last flag to the partial-product selector.
module booth_r4_encoder_seq
  import booth_r4_encoder_seq_pkg::*;
#(
  parameter int N         = 32,
  parameter bit SKIP_ZERO = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  booth_r4_encoder_seq_if.slave   bus
);

  localparam int            GROUPS   = N / 2;
  localparam int            IW       = $clog2(GROUPS);
  localparam logic [IW-1:0] LAST_IDX = IW'(GROUPS - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N:0]    r_sr;
  logic [IW-1:0] r_idx;

  logic [2:0]    w_group;
  logic          w_run;
  logic          w_is_last;
  logic          w_skip;
  logic          w_out_valid;
  logic          w_load;
  logic          w_adv;
  logic          w_done;

  assign w_group     = r_sr[2:0];
  assign w_run       = (r_state == ST_RUN);
  assign w_is_last   = (r_idx == LAST_IDX);
  // The final group is never skipped so out_last always reaches the consumer
  assign w_skip      = SKIP_ZERO && booth_is_zero(w_group) && !w_is_last;
  assign w_out_valid = w_run && !w_skip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // Skipped groups advance as bubble cycles; shown groups wait for out_ready
        if (!w_out_valid || bus.out_ready) begin
          w_adv = 1'b1;
          if (w_is_last) begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // sr[0] holds b[2i-1]; the implicit b[-1]=0 is the appended LSB at load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr  <= '0;
      r_idx <= '0;
    end else if (w_load) begin
      r_sr  <= {bus.in_b, 1'b0};
      r_idx <= '0;
    end else if (w_done) begin
      r_sr  <= '0;
      r_idx <= '0;
    end else if (w_adv) begin
      r_sr  <= r_sr >> 2;
      r_idx <= r_idx + 1'b1;
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE) && rst_n;
  assign bus.out_valid = w_out_valid;
  assign bus.out_cntrl = w_group;
  assign bus.out_idx   = r_idx;
  assign bus.out_last  = w_run && w_is_last;
  assign bus.busy      = w_run;

endmodule
